ncl_adder_sync: RTL and testbench

NCL_ADDER_SYNC -- requirements
Module: ncl_adder_sync

---
 rtl/ncl_adder_sync.sv | 158 +++++++++++++++
 tb/tb_ncl_adder_sync.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ncl_adder_sync.sv
// ncl_adder_sync: clocked adder/subtractor with dual-rail (NCL-style) data ports.
// Operands are captured as one complete-DATA wavefront. STEP digits are resolved
// per cycle through a registered ripple carry. The whole result is then published
// in a single edge, and the block waits for the NULL/acknowledge return-to-zero
// handshake before it accepts the next operation.
module ncl_adder_sync #(
    parameter int WIDTH = 8,
    parameter int STEP  = 4
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic [2*WIDTH-1:0]   A,
    input  logic [2*WIDTH-1:0]   B,
    input  logic [1:0]           carryin,
    input  logic                 sub,
    output logic                 ACOMP,
    output logic                 BCOMP,
    output logic                 carryinCOMP,
    output logic [2*WIDTH-1:0]   sum,
    output logic [1:0]           carryout,
    input  logic                 sumCOMP,
    input  logic                 carryoutCOMP,
    output logic                 err
);

    localparam int N  = WIDTH / STEP;
    localparam int KW = (N < 2) ? 1 : $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, HOLD, RELEASE} state_t;

    state_t              state;
    logic [KW-1:0]       k;
    logic                comp;

    // Datapath registers: operands in binary form, with B already conditioned for subtract.
    logic [WIDTH-1:0]    a_p0;
    logic [WIDTH-1:0]    b_p0;
    logic [WIDTH-1:0]    acc_p1;
    logic                carry_p1;

    logic                in_data;
    logic                in_null;
    logic                in_bad;
    logic                capture;
    logic                step;
    logic [STEP-1:0]     grp_a;
    logic [STEP-1:0]     grp_b;
    logic [STEP:0]       grp_s;

    // Rail1 of each digit is the binary value once the digit is known to be DATA.
    function automatic logic [WIDTH-1:0] rail1(input logic [2*WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[2*i+1];
        end
        return r;
    endfunction

    // Binary to dual-rail: 1 -> DATA1 (10), 0 -> DATA0 (01).
    function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    // Classify the input wavefront: every digit DATA, every digit NULL, or any illegal 11.
    always_comb begin
        in_data = (carryin[1] ^ carryin[0]);
        in_null = ~(carryin[1] | carryin[0]);
        in_bad  = (carryin[1] & carryin[0]);
        for (int i = 0; i < WIDTH; i++) begin
            in_data = in_data & (A[2*i+1] ^ A[2*i]) & (B[2*i+1] ^ B[2*i]);
            in_null = in_null & ~(A[2*i+1] | A[2*i]) & ~(B[2*i+1] | B[2*i]);
            in_bad  = in_bad | (A[2*i+1] & A[2*i]) | (B[2*i+1] & B[2*i]);
        end
    end

    // Group k of the registered operands, added with the registered carry.
    always_comb begin
        grp_a   = STEP'(a_p0 >> (int'(k) * STEP));
        grp_b   = STEP'(b_p0 >> (int'(k) * STEP));
        grp_s   = {1'b0, grp_a} + {1'b0, grp_b} + {{STEP{1'b0}}, carry_p1};
        capture = (state == IDLE) && !in_bad && in_data && !sumCOMP && !carryoutCOMP;
        step    = (state == CALC) && (k != KW'(N));
    end

    // Operand capture and per-cycle digit resolution; result groups shift in from the top.
    // Subtract folds into the add: B is inverted and the carry-in is inverted (borrow-in).
    always_ff @(posedge clk) begin
        if (capture) begin
            a_p0     <= rail1(A);
            b_p0     <= rail1(B) ^ {WIDTH{sub}};
            carry_p1 <= carryin[1] ^ sub;
            acc_p1   <= '0;
        end else if (step) begin
            acc_p1   <= (acc_p1 >> STEP) | (WIDTH'(grp_s[STEP-1:0]) << (WIDTH - STEP));
            carry_p1 <= grp_s[STEP];
        end
    end

    // Handshake FSM: capture, N resolve cycles, one publish edge, hold DATA, return to NULL.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state    <= IDLE;
            k        <= '0;
            comp     <= 1'b0;
            err      <= 1'b0;
            sum      <= '0;
            carryout <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_bad) begin
                        err <= 1'b1;
                    end else if (capture) begin
                        comp  <= 1'b1;
                        k     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (k == KW'(N)) begin
                        // All groups are resolved: publish the full result atomically.
                        sum      <= encode(acc_p1);
                        carryout <= {carry_p1, ~carry_p1};
                        state    <= HOLD;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                HOLD: begin
                    if (in_bad) begin
                        err <= 1'b1;
                    end else if (sumCOMP && carryoutCOMP && in_null) begin
                        sum      <= '0;
                        carryout <= 2'b00;
                        comp     <= 1'b0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!sumCOMP && !carryoutCOMP) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ACOMP       = comp;
    assign BCOMP       = comp;
    assign carryinCOMP = comp;

endmodule

// File: tb/tb_ncl_adder_sync.sv
// Testbench for ncl_adder_sync: directed cases plus randomized add/subtract
// operations, checked against an integer-arithmetic reference.
module tb_ncl_adder_sync;

    localparam int WIDTH = 8;
    localparam int STEP  = 4;

    logic               clk = 1'b0;
    logic               init_n;
    logic [2*WIDTH-1:0] A, B;
    logic [1:0]         carryin;
    logic               sub;
    logic               ACOMP, BCOMP, carryinCOMP;
    logic [2*WIDTH-1:0] sum;
    logic [1:0]         carryout;
    logic               sumCOMP, carryoutCOMP;
    logic               err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ncl_adder_sync #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk(clk), .init_n(init_n), .A(A), .B(B), .carryin(carryin), .sub(sub),
        .ACOMP(ACOMP), .BCOMP(BCOMP), .carryinCOMP(carryinCOMP),
        .sum(sum), .carryout(carryout),
        .sumCOMP(sumCOMP), .carryoutCOMP(carryoutCOMP), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] dr(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [1:0] dr1(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    // Reference: {carryout, sum} from plain integer arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
        int r;
        int mask;
        mask = (1 << WIDTH) - 1;
        if (!s) r = int'(a) + int'(b) + (c ? 1 : 0);
        else    r = int'(a) + (mask - int'(b)) + (c ? 0 : 1);
        return (WIDTH+1)'(r);
    endfunction

    function automatic logic [2:0] comps();
        return {ACOMP, BCOMP, carryinCOMP};
    endfunction

    task automatic start_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input logic s);
        @(negedge clk);
        A = dr(a); B = dr(b); carryin = dr1(c); sub = s;
        @(posedge clk); #1;
        chk({tag, ":capture_comp"}, 64'(comps()), 64'(3'b111));
    endtask

    // From the edge after capture: two NULL cycles, result on the third edge, then release.
    task automatic finish_op(input string tag, input logic [WIDTH:0] exp);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            A = dr(WIDTH'($urandom)); B = dr(WIDTH'($urandom));
            carryin = dr1(1'($urandom)); sub = 1'($urandom);
            @(posedge clk); #1;
            if (e < 3) begin
                chk({tag, ":no_partial"}, 64'(sum), 64'(0));
                chk({tag, ":calc_comp"}, 64'(comps()), 64'(3'b111));
            end
        end
        chk({tag, ":sum"}, 64'(sum), 64'(dr(exp[WIDTH-1:0])));
        chk({tag, ":cout"}, 64'(carryout), 64'(dr1(exp[WIDTH])));
        @(negedge clk);
        A = '0; B = '0; carryin = 2'b00; sumCOMP = 1'b1; carryoutCOMP = 1'b1;
        @(posedge clk); #1;
        chk({tag, ":null_sum"}, 64'({sum, carryout}), 64'(0));
        chk({tag, ":null_comp"}, 64'(comps()), 64'(3'b000));
        @(negedge clk);
        sumCOMP = 1'b0; carryoutCOMP = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input logic [WIDTH:0] exp);
        start_op(tag, a, b, c, s);
        finish_op(tag, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;

        init_n = 1'b0; A = '0; B = '0; carryin = 2'b00; sub = 1'b0;
        sumCOMP = 1'b0; carryoutCOMP = 1'b0;
        #12;
        chk("reset_sum", 64'({sum, carryout}), 64'(0));
        chk("reset_comp", 64'(comps()), 64'(3'b000));
        chk("reset_err", 64'(err), 64'(0));
        @(negedge clk); init_n = 1'b1;

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 9'h10F);
        run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF);
        run_op("add_cin1", 8'hFF, 8'h00, 1'b1, 1'b0, 9'h100);
        run_op("sub_bin1", 8'h05, 8'h05, 1'b1, 1'b1, 9'h0FF);

        // Backpressure: a held sumCOMP blocks capture.
        @(negedge clk);
        sumCOMP = 1'b1;
        A = dr(8'h12); B = dr(8'h34); carryin = dr1(1'b0); sub = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_no_capture", 64'(comps()), 64'(3'b000));
        end
        @(negedge clk); sumCOMP = 1'b0;
        @(posedge clk); #1;
        chk("bp_capture", 64'(comps()), 64'(3'b111));
        finish_op("bp_op", 9'h046);

        // Illegal digit in IDLE: sticky err, no capture.
        @(negedge clk);
        A = dr(8'h33); A[5:4] = 2'b11; B = dr(8'h01); carryin = dr1(1'b0); sub = 1'b0;
        @(posedge clk); #1;
        chk("err_set", 64'(err), 64'(1));
        chk("err_no_capture", 64'(comps()), 64'(3'b000));
        @(negedge clk); A = '0; B = '0; carryin = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(err), 64'(1));
        @(negedge clk); init_n = 1'b0;
        #1;
        chk("err_cleared", 64'(err), 64'(0));
        @(negedge clk); init_n = 1'b1;

        // Reset in the middle of CALC.
        start_op("rst_mid", 8'h77, 8'h11, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        init_n = 1'b0; A = '0; B = '0; carryin = 2'b00;
        #1;
        chk("rst_mid_null", 64'({sum, carryout}), 64'(0));
        chk("rst_mid_comp", 64'(comps()), 64'(3'b000));
        @(negedge clk); init_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_quiet", 64'({sum, carryout}), 64'(0));
        run_op("after_rst", 8'hC8, 8'h64, 1'b0, 1'b0, model(8'hC8, 8'h64, 1'b0, 1'b0));

        // Randomized operations against the integer reference.
        for (int n = 0; n < 24; n++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rc = 1'($urandom);     rs = 1'($urandom);
            run_op("rand", ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
